// File: rtl/lcd_pkg.sv
// Definitions shared by the LCD command sequencer and the LCD controller:
// opcodes, sequencer state encoding and the reserved-opcode test.
package lcd_pkg;

  localparam logic [3:0] OP_WRITE    = 4'd0;
  localparam logic [3:0] OP_UP       = 4'd1;
  localparam logic [3:0] OP_DOWN     = 4'd2;
  localparam logic [3:0] OP_LEFT     = 4'd3;
  localparam logic [3:0] OP_RIGHT    = 4'd4;
  localparam logic [3:0] OP_MAX      = 4'd5;
  localparam logic [3:0] OP_MIN      = 4'd6;
  localparam logic [3:0] OP_AVG      = 4'd7;
  localparam logic [3:0] OP_CCW      = 4'd8;
  localparam logic [3:0] OP_CW       = 4'd9;
  localparam logic [3:0] OP_MIRROR_X = 4'd10;
  localparam logic [3:0] OP_MIRROR_Y = 4'd11;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_BUSY = 4'd1,
    S_FETCH     = 4'd2,
    S_LATCH     = 4'd3,
    S_ISSUE     = 4'd4,
    S_HOLD      = 4'd5,
    S_WAIT_DONE = 4'd6,
    S_FINISH    = 4'd7,
    S_ERROR     = 4'd8
  } seq_state_t;

  // Codes 12..15 have no controller meaning and are skipped by the sequencer.
  function automatic logic op_reserved(input logic [3:0] op);
    return (op > OP_MIRROR_Y);
  endfunction

endpackage

// File: rtl/lcd_seq_wdog.sv
// Wait-cycle watchdog: counts consecutive cycles with run high and flags
// expiry once the count reaches TIMEOUT; any cycle with run low clears it.
module lcd_seq_wdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = (r_cnt == LIMIT);

endmodule

// File: rtl/lcd_cmd_seq.sv
// Fetches opcodes from the command ROM and issues them to the LCD controller,
// paced by busy, finishing on done after WRITE; a watchdog catches stalls.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int CMD_AW  = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              CMDROM_rd,
  output logic [CMD_AW-1:0] CMDROM_A,
  input  logic [3:0]        CMDROM_Q,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  output logic              seq_done,
  output logic              timeout_err,
  output logic [6:0]        cmd_count,
  output seq_state_t        dbg_state
);

  // Handshake: cmd_valid is a one-cycle strobe with no ready; the controller
  // accepts every strobe and paces the next one by holding busy high.
  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [CMD_AW-1:0] r_addr;
  logic [3:0]        r_cmd;
  logic [6:0]        r_count;
  logic              r_seq_done;
  logic              w_run;
  logic              w_expired;
  logic              w_addr_last;
  logic              w_exhausted;

  assign w_addr_last = (r_addr == {CMD_AW{1'b1}});
  assign w_exhausted = w_addr_last && (r_cmd != OP_WRITE);
  assign w_run       = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

  lcd_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .run     (w_run),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        // Expiry wins even if busy drops in the same cycle.
        if (w_expired)  w_state_nxt = S_ERROR;
        else if (!busy) w_state_nxt = S_FETCH;
      end
      S_FETCH:     w_state_nxt = S_LATCH;
      S_LATCH: begin
        if (op_reserved(CMDROM_Q)) w_state_nxt = w_addr_last ? S_ERROR : S_FETCH;
        else                       w_state_nxt = S_ISSUE;
      end
      S_ISSUE:     w_state_nxt = w_exhausted ? S_ERROR : S_HOLD;
      S_HOLD:      w_state_nxt = (r_cmd == OP_WRITE) ? S_WAIT_DONE : S_WAIT_BUSY;
      S_WAIT_DONE: begin
        if (w_expired) w_state_nxt = S_ERROR;
        else if (done) w_state_nxt = S_FINISH;
      end
      S_FINISH:    w_state_nxt = S_IDLE;
      S_ERROR:     w_state_nxt = S_ERROR;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_cmd      <= OP_WRITE;
      r_count    <= '0;
      r_seq_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_seq_done <= 1'b0;
          end
        end
        S_LATCH: begin
          r_cmd <= CMDROM_Q;
          if (op_reserved(CMDROM_Q) && !w_addr_last) r_addr <= r_addr + CMD_AW'(1);
        end
        S_ISSUE: begin
          if (r_count != 7'h7F) r_count <= r_count + 7'd1;
          // Address is left on the last entry when the ROM runs out.
          if (!w_exhausted) r_addr <= r_addr + CMD_AW'(1);
        end
        S_FINISH: r_seq_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign CMDROM_rd   = (r_state == S_FETCH);
  assign CMDROM_A    = r_addr;
  assign cmd         = r_cmd;
  assign cmd_valid   = (r_state == S_ISSUE);
  assign seq_done    = r_seq_done;
  assign timeout_err = (r_state == S_ERROR);
  assign cmd_count   = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: one instance with default parameters and
// one small instance (CMD_AW=2, TIMEOUT=8) for watchdog and ROM exhaustion.
module tb_lcd_cmd_seq;
  import lcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- instance A (defaults) ----------------
  logic       a_reset = 1'b1, a_start = 1'b0;
  logic       a_rd, a_valid, a_busy = 1'b0, a_done = 1'b0, a_seq_done, a_terr;
  logic [5:0] a_addr;
  logic [3:0] a_q = 4'd0, a_cmd;
  logic [6:0] a_count;
  seq_state_t a_state;
  logic [3:0] a_rom [64];

  lcd_cmd_seq u_a (
    .clk(clk), .reset(a_reset), .start(a_start),
    .CMDROM_rd(a_rd), .CMDROM_A(a_addr), .CMDROM_Q(a_q),
    .cmd(a_cmd), .cmd_valid(a_valid), .busy(a_busy), .done(a_done),
    .seq_done(a_seq_done), .timeout_err(a_terr), .cmd_count(a_count),
    .dbg_state(a_state)
  );

  // ---------------- instance B (small) ----------------
  logic       b_reset = 1'b1, b_start = 1'b0;
  logic       b_rd, b_valid, b_busy = 1'b0, b_done = 1'b0, b_seq_done, b_terr;
  logic [1:0] b_addr;
  logic [3:0] b_q = 4'd0, b_cmd;
  logic [6:0] b_count;
  seq_state_t b_state;
  logic [3:0] b_rom [4];

  lcd_cmd_seq #(.CMD_AW(2), .TIMEOUT(8)) u_b (
    .clk(clk), .reset(b_reset), .start(b_start),
    .CMDROM_rd(b_rd), .CMDROM_A(b_addr), .CMDROM_Q(b_q),
    .cmd(b_cmd), .cmd_valid(b_valid), .busy(b_busy), .done(b_done),
    .seq_done(b_seq_done), .timeout_err(b_terr), .cmd_count(b_count),
    .dbg_state(b_state)
  );

  // Synchronous command ROMs: data valid the cycle after the read enable.
  always @(posedge clk) if (a_rd) a_q <= a_rom[a_addr];
  always @(posedge clk) if (b_rd) b_q <= b_rom[b_addr];

  // ---------------- controller model + monitors ----------------
  int   a_busy_len = 2;
  int   a_done_dly = 70;
  int   a_bcnt = 0;
  int   a_dcnt = 0;
  logic a_boot = 1'b1;
  logic [31:0] a_cmd_q[$], a_t_q[$], a_addr_q[$], b_cmd_q[$];

  always @(negedge clk) begin
    a_busy = a_boot || (a_bcnt > 0);
    a_done = (a_dcnt == 1);
    if (a_dcnt > 0) a_dcnt--;
    if (a_bcnt > 0) a_bcnt--;
    if (a_valid === 1'b1) begin
      if (a_cmd == OP_WRITE) a_dcnt = a_done_dly;
      else                   a_bcnt = a_busy_len;
      a_cmd_q.push_back(32'(a_cmd));
      a_t_q.push_back(32'(cyc));
    end
    if (a_rd === 1'b1) a_addr_q.push_back(32'(a_addr));
    if (b_valid === 1'b1) b_cmd_q.push_back(32'(b_cmd));
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_a_start(output int s);
    step();
    a_start = 1'b1;
    s = cyc;
    step();
    a_start = 1'b0;
  endtask

  task automatic pulse_b_start();
    step();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
  endtask

  task automatic wait_a_seq_done(input string tag, input int lim);
    int n = 0;
    while (a_seq_done !== 1'b1 && n < lim) begin step(); n++; end
    check(tag, 32'(a_seq_done), 32'd1);
  endtask

  task automatic wait_a_done(input string tag, input int lim);
    int n = 0;
    while (a_done !== 1'b1 && n < lim) begin step(); n++; end
    check(tag, 32'(a_done), 32'd1);
  endtask

  task automatic wait_a_valid(input string tag, input int lim);
    int n = 0;
    while (a_valid !== 1'b1 && n < lim) begin step(); n++; end
    check(tag, 32'(a_valid), 32'd1);
  endtask

  task automatic wait_b_valid(input string tag, input int lim);
    int n = 0;
    while (b_valid !== 1'b1 && n < lim) begin step(); n++; end
    check(tag, 32'(b_valid), 32'd1);
  endtask

  task automatic wait_b_terr(input string tag, input int lim);
    int n = 0;
    while (b_terr !== 1'b1 && n < lim) begin step(); n++; end
    check(tag, 32'(b_terr), 32'd1);
  endtask

  task automatic check_a_reset_vals(input string tag);
    check({tag, "_rd"},    32'(a_rd),       32'd0);
    check({tag, "_addr"},  32'(a_addr),     32'd0);
    check({tag, "_cmd"},   32'(a_cmd),      32'd0);
    check({tag, "_valid"}, 32'(a_valid),    32'd0);
    check({tag, "_sdone"}, 32'(a_seq_done), 32'd0);
    check({tag, "_terr"},  32'(a_terr),     32'd0);
    check({tag, "_count"}, 32'(a_count),    32'd0);
    check({tag, "_state"}, 32'(a_state),    32'(S_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int s;
    int t;
    for (int i = 0; i < 64; i++) a_rom[i] = 4'd1;
    for (int i = 0; i < 4; i++)  b_rom[i] = 4'd1;

    repeat (3) step();
    check_a_reset_vals("rst");
    check("rst_b_terr", 32'(b_terr), 32'd0);
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Nominal: busy held after reset, then 1,5,9,WRITE; done 70 after WRITE.
    a_rom[0] = 4'd1; a_rom[1] = 4'd5; a_rom[2] = 4'd9; a_rom[3] = 4'd0;
    a_busy_len = 2; a_done_dly = 70;
    pulse_a_start(s);
    repeat (62) step();
    a_boot = 1'b0;
    wait_a_done("nom_done_seen", 400);
    step();
    check("nom_sdone_d1", 32'(a_seq_done), 32'd0);
    check("nom_state_d1", 32'(a_state), 32'(S_FINISH));
    step();
    check("nom_sdone_d2", 32'(a_seq_done), 32'd1);
    check("nom_state_d2", 32'(a_state), 32'(S_IDLE));
    exp_q = '{32'd1, 32'd5, 32'd9, 32'd0};
    got_q = a_cmd_q;
    cmp_q("nom_cmds");
    check("nom_count", 32'(a_count), 32'd4);
    check("nom_terr",  32'(a_terr),  32'd0);

    // Reserved opcodes skipped but their addresses still read.
    a_cmd_q.delete(); a_t_q.delete(); a_addr_q.delete();
    a_rom[0] = 4'd3; a_rom[1] = 4'd12; a_rom[2] = 4'd15; a_rom[3] = 4'd4; a_rom[4] = 4'd0;
    a_busy_len = 0; a_done_dly = 3;
    pulse_a_start(s);
    check("rsv_sdone_clr", 32'(a_seq_done), 32'd0);
    wait_a_seq_done("rsv_sdone", 100);
    exp_q = '{32'd3, 32'd4, 32'd0};
    got_q = a_cmd_q;
    cmp_q("rsv_cmds");
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    got_q = a_addr_q;
    cmp_q("rsv_addrs");
    check("rsv_count", 32'(a_count), 32'd3);

    // Late busy (2 cycles after each strobe) and a start ignored mid-run.
    a_cmd_q.delete(); a_t_q.delete(); a_addr_q.delete();
    a_rom[0] = 4'd1; a_rom[1] = 4'd5; a_rom[2] = 4'd0;
    a_busy_len = 2; a_done_dly = 5;
    pulse_a_start(s);
    repeat (4) step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    wait_a_seq_done("late_sdone", 100);
    exp_q = '{32'(s + 4), 32'(s + 10), 32'(s + 16)};
    got_q = a_t_q;
    cmp_q("late_times");
    exp_q = '{32'd1, 32'd5, 32'd0};
    got_q = a_cmd_q;
    cmp_q("late_cmds");
    check("late_count", 32'(a_count), 32'd3);

    // Reset asserted during ISSUE, then a clean replay from address 0.
    a_cmd_q.delete(); a_t_q.delete(); a_addr_q.delete();
    a_rom[0] = 4'd2; a_rom[1] = 4'd0;
    a_busy_len = 0; a_done_dly = 3;
    pulse_a_start(s);
    wait_a_valid("rr_issue_seen", 20);
    a_reset = 1'b1;
    step();
    check_a_reset_vals("rr");
    step();
    a_reset = 1'b0;
    repeat (5) step();
    check("rr_no_issue", 32'(a_cmd_q.size()), 32'd1);
    check("rr_idle", 32'(a_state), 32'(S_IDLE));
    a_cmd_q.delete(); a_addr_q.delete();
    pulse_a_start(s);
    wait_a_seq_done("rr_sdone", 100);
    exp_q = '{32'd0, 32'd1};
    got_q = a_addr_q;
    cmp_q("rr_addrs");
    exp_q = '{32'd2, 32'd0};
    got_q = a_cmd_q;
    cmp_q("rr_cmds");
    check("rr_count", 32'(a_count), 32'd2);

    // Watchdog: busy sticks high from the first strobe, TIMEOUT=8.
    b_rom[0] = 4'd1; b_rom[1] = 4'd1; b_rom[2] = 4'd1; b_rom[3] = 4'd1;
    b_busy = 1'b0;
    pulse_b_start();
    wait_b_valid("wd_issue_seen", 20);
    t = cyc;
    b_busy = 1'b1;
    repeat (10) step();
    check("wd_terr_early", 32'(b_terr), 32'd0);
    step();
    check("wd_terr_fire", 32'(b_terr), 32'd1);
    check("wd_state", 32'(b_state), 32'(S_ERROR));
    check("wd_cycle", 32'(cyc), 32'(t + 11));
    repeat (20) step();
    check("wd_issues", 32'(b_cmd_q.size()), 32'd1);
    check("wd_sticky", 32'(b_terr), 32'd1);
    check("wd_sdone", 32'(b_seq_done), 32'd0);

    // ROM exhaustion: four non-WRITE opcodes fill a 4-entry ROM.
    b_reset = 1'b1;
    b_busy  = 1'b0;
    repeat (2) step();
    check("ex_rst_terr", 32'(b_terr), 32'd0);
    b_reset = 1'b0;
    b_cmd_q.delete();
    b_rom[0] = 4'd1; b_rom[1] = 4'd2; b_rom[2] = 4'd3; b_rom[3] = 4'd4;
    pulse_b_start();
    wait_b_terr("ex_terr", 60);
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    got_q = b_cmd_q;
    cmp_q("ex_cmds");
    check("ex_count", 32'(b_count), 32'd4);
    check("ex_sdone", 32'(b_seq_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got stalled want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
